// File: rtl/rnn_out_argmax_if.sv
// Result channel of rnn_out_argmax: per-timestep argmax entries drained with valid/ready.
// The master drives valid and the head entry; the slave returns ready.
interface rnn_out_argmax_if #(
  parameter int FLEN = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_step;
  logic [1:0]      out_class;
  logic [FLEN-1:0] out_max;

  modport master (output out_valid, out_step, out_class, out_max, input out_ready);
  modport slave  (input out_valid, out_step, out_class, out_max, output out_ready);
endinterface

// File: rtl/rnn_out_argmax.sv
// Per-timestep argmax over the RNN's 9-beat output frame, results queued in a small FIFO.
// Define RNN_OUT_RELU_EN to clamp negative scores to +0 before compare and storage.
module rnn_out_argmax #(
  parameter int inst_sig_width = 23,
  parameter int inst_exp_width = 8,
  parameter int FLEN           = inst_sig_width + inst_exp_width + 1,
  parameter int DEPTH          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [FLEN-1:0]  in_data,
  rnn_out_argmax_if.master res,
  output logic             frame_done,
  output logic             overflow,
  output logic             short_frame
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  typedef struct packed {
    logic [1:0]      step;
    logic [1:0]      cls;
    logic [FLEN-1:0] max;
  } entry_t;

  state_t          state_reg;
  logic [1:0]      elem_reg;
  logic [1:0]      step_reg;
  logic [FLEN-1:0] run_max_reg;
  logic [1:0]      run_idx_reg;
  logic            frame_done_reg;
  logic            short_frame_reg;
  logic            overflow_reg;

  entry_t          mem [DEPTH];
  entry_t          head_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   rd_next;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            out_valid_reg;

  logic [FLEN-1:0] score;
  logic            score_gt;
  logic            push;
  logic            pop;
  logic            full;
  logic            wr_en;
  entry_t          wr_entry;

  // Sign-magnitude "a > b"; +0 and -0 compare equal, no NaN/Inf special cases.
  function automatic logic fp_gt(input logic [FLEN-1:0] a, input logic [FLEN-1:0] b);
    logic [FLEN-2:0] ma;
    logic [FLEN-2:0] mb;
    ma = a[FLEN-2:0];
    mb = b[FLEN-2:0];
    if (ma == '0 && mb == '0) return 1'b0;
    if (a[FLEN-1] != b[FLEN-1]) return ~a[FLEN-1];
    if (!a[FLEN-1]) return ma > mb;
    return ma < mb;
  endfunction

`ifdef RNN_OUT_RELU_EN
  assign score = in_data[FLEN-1] ? '0 : in_data;
`else
  assign score = in_data;
`endif

  assign score_gt = fp_gt(score, run_max_reg);
  assign push     = in_valid && (state_reg == COLLECT) && (elem_reg == 2'd2);
  assign pop      = out_valid_reg && res.out_ready;
  assign full     = (count_reg == CW'(DEPTH));
  assign wr_en    = push && (!full || pop);
  assign rd_next  = rd_ptr_reg + AW'(1);

  // The group's last element takes part in the compare before the entry is written.
  always_comb begin
    wr_entry.step = step_reg;
    wr_entry.cls  = score_gt ? 2'd2 : run_idx_reg;
    wr_entry.max  = score_gt ? score : run_max_reg;
  end

  always_comb begin
    count_next = count_reg;
    if (wr_en && !pop) count_next = count_reg + CW'(1);
    else if (!wr_en && pop) count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      elem_reg        <= 2'd0;
      step_reg        <= 2'd0;
      run_max_reg     <= '0;
      run_idx_reg     <= 2'd0;
      frame_done_reg  <= 1'b0;
      short_frame_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg   <= COLLECT;
            elem_reg    <= 2'd1;
            step_reg    <= 2'd0;
            run_max_reg <= score;
            run_idx_reg <= 2'd0;
          end
        end
        COLLECT: begin
          if (!in_valid) begin
            short_frame_reg <= 1'b1;
            state_reg       <= IDLE;
            elem_reg        <= 2'd0;
            step_reg        <= 2'd0;
          end else if (elem_reg == 2'd2) begin
            elem_reg <= 2'd0;
            if (step_reg == 2'd2) begin
              state_reg      <= DRAIN;
              step_reg       <= 2'd0;
              frame_done_reg <= 1'b1;
            end else begin
              step_reg <= step_reg + 2'd1;
            end
          end else begin
            elem_reg <= elem_reg + 2'd1;
            if (elem_reg == 2'd0) begin
              run_max_reg <= score;
              run_idx_reg <= 2'd0;
            end else if (score_gt) begin
              run_max_reg <= score;
              run_idx_reg <= elem_reg;
            end
          end
        end
        DRAIN: begin
          if (!in_valid) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_entry;
  end

  // Head register mirrors mem[rd_ptr]; bypass the write data when the new head is the entry being pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      head_reg      <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      count_reg     <= count_next;
      out_valid_reg <= (count_next != '0);
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) rd_ptr_reg <= rd_next;
      if (push && full && !pop) overflow_reg <= 1'b1;
      if (wr_en && count_reg == '0) head_reg <= wr_entry;
      else if (pop && count_reg > CW'(1)) head_reg <= mem[rd_next];
      else if (pop && wr_en) head_reg <= wr_entry;
    end
  end

  assign res.out_valid = out_valid_reg;
  assign res.out_step  = head_reg.step;
  assign res.out_class = head_reg.cls;
  assign res.out_max   = head_reg.max;
  assign frame_done    = frame_done_reg;
  assign overflow      = overflow_reg;
  assign short_frame   = short_frame_reg;
endmodule

// File: tb/tb_rnn_out_argmax.sv
// Bench for rnn_out_argmax: directed frames plus random traffic against a queue-based model.
// Score order in the model comes from mapping sign-magnitude words onto signed integers.
module tb_rnn_out_argmax;
  localparam int FLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    int          step;
    int          cls;
    logic [31:0] mx;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        frame_done;
  logic        overflow;
  logic        short_frame;

  rnn_out_argmax_if #(.FLEN(FLEN)) res_if();

  rnn_out_argmax #(
    .inst_sig_width(23),
    .inst_exp_width(8),
    .FLEN(FLEN),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .res(res_if),
    .frame_done(frame_done),
    .overflow(overflow),
    .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  ent_t        exp_q[$];
  ent_t        dut_pops[$];
  int          run_len = 0;
  logic [31:0] grp[3];
  logic [31:0] frm[16];
  bit          exp_fd = 0;
  bit          exp_ovf = 0;
  bit          exp_short = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint score_key(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] clamp(input logic [31:0] x);
`ifdef RNN_OUT_RELU_EN
    if (x[31]) return 32'h0;
`endif
    return x;
  endfunction

  function automatic ent_t best_of(input int step);
    ent_t e;
    int   bi;
    bi = 0;
    for (int k = 1; k < 3; k++)
      if (score_key(grp[k]) > score_key(grp[bi])) bi = k;
    e.step = step;
    e.cls  = bi;
    e.mx   = grp[bi];
    return e;
  endfunction

  function automatic logic [31:0] pick_score();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h3F80_0000;
      3: return 32'hBF80_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic rdy_of(input int mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return mode == 1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    run_len   = 0;
    exp_fd    = 0;
    exp_ovf   = 0;
    exp_short = 0;
  endtask

  // One clock edge of the reference: frame = contiguous valid run, first 9 beats count.
  task automatic model_step(input logic v, input logic [31:0] d, input logic rdy);
    bit   do_pop;
    bit   do_push;
    int   size_before;
    ent_t pe;
    ent_t dummy;
    do_push = 0;
    exp_fd  = 0;
    if (v) begin
      if (run_len < 9) begin
        grp[run_len % 3] = clamp(d);
        if (run_len % 3 == 2) begin
          do_push = 1;
          pe = best_of(run_len / 3);
        end
        if (run_len == 8) exp_fd = 1;
      end
      if (run_len < 100) run_len++;
    end else begin
      if (run_len > 0 && run_len < 9) exp_short = 1;
      run_len = 0;
    end
    size_before = exp_q.size();
    do_pop = (size_before != 0) && rdy;
    if (do_pop) dummy = exp_q.pop_front();
    if (do_push) begin
      if (size_before < DEPTH || do_pop) exp_q.push_back(pe);
      else exp_ovf = 1;
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] d, input logic rdy);
    ent_t e;
    in_valid = v;
    in_data = d;
    res_if.out_ready = rdy;
    if (res_if.out_valid && rdy) begin
      e.step = int'(res_if.out_step);
      e.cls  = int'(res_if.out_class);
      e.mx   = res_if.out_max;
      dut_pops.push_back(e);
      $display("pop  step=%0d class=%0d max=%08h", e.step, e.cls, e.mx);
    end
    @(posedge clk);
    model_step(v, d, rdy);
    @(negedge clk);
    check_eq("out_valid", res_if.out_valid, exp_q.size() != 0);
    check_eq("frame_done", frame_done, exp_fd);
    check_eq("overflow", overflow, exp_ovf);
    check_eq("short_frame", short_frame, exp_short);
    if (exp_q.size() != 0) begin
      check_eq("out_step", res_if.out_step, exp_q[0].step);
      check_eq("out_class", res_if.out_class, exp_q[0].cls);
      check_eq("out_max", res_if.out_max, exp_q[0].mx);
    end
  endtask

  task automatic run_frame(input int nbeats, input int gap, input int rmode);
    for (int i = 0; i < nbeats; i++) cycle(1'b1, frm[i], rdy_of(rmode));
    for (int i = 0; i < gap; i++) cycle(1'b0, $urandom, rdy_of(rmode));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) frm[i] = pick_score();
  endtask

  task automatic check_pops(input string tag, input int n);
    check_eq({tag, "_count"}, dut_pops.size(), n);
    for (int i = 0; i < n && i < dut_pops.size(); i++)
      check_eq({tag, "_step"}, dut_pops[i].step, i % 3);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, res_if.out_valid, 0);
    check_eq({tag, "_step"}, res_if.out_step, 0);
    check_eq({tag, "_class"}, res_if.out_class, 0);
    check_eq({tag, "_max"}, res_if.out_max, 0);
    check_eq({tag, "_fd"}, frame_done, 0);
    check_eq({tag, "_ovf"}, overflow, 0);
    check_eq({tag, "_short"}, short_frame, 0);
  endtask

  initial begin
    res_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    model_reset();

    // Directed frame with known winners, including a three-way tie
    frm[0] = 32'h3F80_0000; frm[1] = 32'h4000_0000; frm[2] = 32'h3F00_0000;
    frm[3] = 32'hC040_0000; frm[4] = 32'hBF80_0000; frm[5] = 32'hC000_0000;
    frm[6] = 32'h3F00_0000; frm[7] = 32'h3F00_0000; frm[8] = 32'h3F00_0000;
    dut_pops.delete();
    run_frame(9, 4, 1);
    check_pops("dir", 3);
    if (dut_pops.size() == 3) begin
      check_eq("dir_c0", dut_pops[0].cls, 1);
      check_eq("dir_m0", dut_pops[0].mx, 32'h4000_0000);
`ifdef RNN_OUT_RELU_EN
      check_eq("dir_c1", dut_pops[1].cls, 0);
      check_eq("dir_m1", dut_pops[1].mx, 32'h0000_0000);
`else
      check_eq("dir_c1", dut_pops[1].cls, 1);
      check_eq("dir_m1", dut_pops[1].mx, 32'hBF80_0000);
`endif
      check_eq("dir_c2", dut_pops[2].cls, 0);
      check_eq("dir_m2", dut_pops[2].mx, 32'h3F00_0000);
    end

    // Long valid run: beats past the ninth are junk
    fill_random();
    dut_pops.delete();
    run_frame(14, 4, 1);
    check_pops("long", 3);

    // Two frames into a stalled consumer overflow the FIFO
    fill_random();
    run_frame(9, 1, 0);
    fill_random();
    run_frame(9, 2, 0);
    check_eq("ovf_set", overflow, 1);
    dut_pops.delete();
    repeat (6) cycle(1'b0, 32'h0, 1'b1);
    check_pops("ovf_drain", 4);

    // Asynchronous reset mid-frame with a non-empty FIFO
    fill_random();
    for (int i = 0; i < 5; i++) cycle(1'b1, frm[i], 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    dut_pops.delete();
    run_frame(9, 3, 1);
    check_pops("post_rst", 3);

    // Full FIFO with a pop on the push edge: nothing dropped
    fill_random();
    run_frame(9, 1, 0);
    fill_random();
    for (int i = 0; i < 9; i++) cycle(1'b1, frm[i], i >= 5);
    repeat (6) cycle(1'b0, 32'h0, 1'b1);
    check_eq("full_pop_ovf", overflow, 0);

    // Short frame keeps its completed group, then a normal frame
    fill_random();
    dut_pops.delete();
    run_frame(5, 3, 1);
    check_eq("short_set", short_frame, 1);
    check_pops("short", 1);
    fill_random();
    dut_pops.delete();
    run_frame(9, 3, 1);
    check_pops("after_short", 3);

    // All-negative group with a negative zero
    fill_random();
    frm[0] = 32'hBF80_0000; frm[1] = 32'hC000_0000; frm[2] = 32'h8000_0000;
    dut_pops.delete();
    run_frame(9, 3, 1);
    check_eq("neg_count", dut_pops.size(), 3);
    if (dut_pops.size() != 0) begin
`ifdef RNN_OUT_RELU_EN
      check_eq("neg_class", dut_pops[0].cls, 0);
      check_eq("neg_max", dut_pops[0].mx, 32'h0000_0000);
`else
      check_eq("neg_class", dut_pops[0].cls, 2);
      check_eq("neg_max", dut_pops[0].mx, 32'h8000_0000);
`endif
    end

    // Random frame lengths, gaps and back-pressure
    repeat (30) begin
      fill_random();
      run_frame($urandom_range(1, 14), $urandom_range(1, 3), 2);
    end
    repeat (8) cycle(1'b0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
